mem_bus_ctrl: RTL and testbench
===============================

# mem_bus_ctrl

Parametrised memory-system controller between the CPU load/store unit and on-chip storage. It decodes a 32-bit address into ROM, heap, stack and MMIO regions, and runs a request/acknowledge handshake whose latency depends on the region. It signals unmapped accesses and holds the LCD, page and interrupt-vector registers. This is the successor to the single-cycle memory map: configurable widths and read latency, a real ready/ack protocol, and bus error reporting.

## Interface
- DATA_W, 16, data bus width; MMIO registers are zero-extended or truncated to it.
- ROM_AW, 10, ROM word-address bits.
- STACK_AW, 10, stack RAM address bits.
- HEAP_AW, 12, heap RAM address bits.
- MEM_RD_LAT, 1, read latency of ROM and RAMs in cycles (≥1).
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- req  in  1  request; sampled only while busy=0.
- we  in  1  write when high, read when low (qualifies req).
- addr  in  32  word address.
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  read data; valid only while ack=1.
- ack  out  1  one-cycle completion pulse.
- err  out  1  unmapped access; valid only while ack=1.
- busy  out  1  transaction in flight.
- rom_addr  out  ROM_AW  address to external ROM.
- rom_q  in  DATA_W  ROM data, MEM_RD_LAT cycles after rom_addr.
- lcd_pins  out  11  {ctrl[2:0], data[7:0]}.
- page  out  16  page register.
- int_addr  out  32  {int_hi, int_lo}.
- int_en  out  1  interrupt enable.

## Operation
- Region map, inclusive ranges:
  - ROM: 0x00000000–0x000FFFFF.
  - HEAP: 0x10000000–0x8FFFFFFF.
  - STACK: 0xD0000000–0xD000FFFF.
  - LCD_DATA: 0xFFFF0000. LCD_CTRL: 0xFFFF0001.
  - PAGE: 0xFFFF1000.
  - INT_EN: 0xFFFFFFFD. INT_LO: 0xFFFFFFFE. INT_HI: 0xFFFFFFFF.
  - Everything else is NONE.
- Memories use the low AW bits of addr, so each region aliases.
- FSM states and transitions:
  - IDLE: on req, latch addr/we/wdata, decode, go to ACCESS.
  - ACCESS: memory reads go to WAIT; everything else goes to IDLE with ack.
  - WAIT: count MEM_RD_LAT-1 further cycles, capture the memory output into rdata, then go to IDLE with ack.
- Writes:
  - RAM wren is asserted for exactly one cycle (ACCESS) and only for its own region.
  - Writes to ROM are dropped; ack=1, err=0.
  - LCD_DATA takes wdata[7:0]; LCD_CTRL takes wdata[2:0]; PAGE takes wdata[15:0].
  - INT_LO and INT_HI take wdata[15:0]; INT_EN takes |wdata.
- NONE region: ack=1, err=1, rdata=0, no state change.
- When req and we are both high the access is a write. A read never modifies anything.
- MMIO reads: see Configuration.

## Timing
- Acceptance edge E0 is the edge where req=1 and busy=0.
- Writes, MMIO accesses and NONE: ack is high in the cycle after E1 (latency 1).
- ROM/RAM reads: ack is high in the cycle after E(1+MEM_RD_LAT) (default latency 2).
- busy rises after E0 and falls in the ack cycle. A req held in the ack cycle is accepted at the next edge, so at most one transaction per 2 cycles (writes).
- ack, err and rdata are registered. ack lasts exactly one cycle. rdata and err return to 0 after the ack cycle.
- Reset values:
  - ack, err, busy, rdata: 0.
  - lcd_pins, page, int_addr: 0.
  - int_en: 1.
  - FSM: IDLE.
- Reset mid-transaction aborts it with no ack.
- RAM wren is gated by !rst, so an aborted write is never committed.

## Configuration
- MEM_BUS_CTRL_MMIO_READBACK_EN defined: MMIO reads return the register value zero-extended to DATA_W.
  - LCD_DATA returns {0,data}; LCD_CTRL returns {0,ctrl}; INT_EN returns {0,int_en}.
- Undefined: all MMIO reads return 0. Latency and ack are unchanged.

## Structure
- Package mem_bus_pkg holds:
  - region base/limit and MMIO address constants;
  - region enum (NONE, ROM, HEAP, STACK, LCD_DATA, LCD_CTRL, PAGE, INT_EN, INT_LO, INT_HI);
  - FSM state enum (IDLE, ACCESS, WAIT).
- Sub-module bus_sram: single-port synchronous RAM with AW/DW/LAT parameters and an output pipeline of LAT stages. It is instantiated twice, for stack and heap. ROM stays external.

## Test plan
- Write 0x1234 to 0xD0000005, then read it back. Expect write ack at latency 1 and read ack at latency 2 with rdata=0x1234, err=0.
- Write 0xBEEF to 0x10000003, then read 0x10001003. Aliasing with HEAP_AW=12 returns 0xBEEF.
- Write INT_LO=0x5678, INT_HI=0x0001, INT_EN=0. Expect int_addr=0x00015678 and int_en=0; a LCD_CTRL write of 0x7 gives lcd_pins[10:8]=3'b111.
- Read 0x90000000. Expect ack at latency 1 with err=1, rdata=0. Read INT_LO: 0x5678 with MEM_BUS_CTRL_MMIO_READBACK_EN defined, 0 without it.
- Hold req high for 10 cycles with alternating writes. Expect exactly 5 acks and no request accepted while busy=1.
- Assert rst in the ACCESS cycle of a stack write of 0xAAAA. Expect no ack, all outputs at reset values, and a later read returns the old data.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared address map, region and FSM encodings for the memory bus controller.
// No logic: constants, enums and the address decoder only.
// Backpressure: not applicable.
package mem_bus_pkg;

    localparam logic [31:0] ROM_BASE      = 32'h0000_0000;
    localparam logic [31:0] ROM_LIMIT     = 32'h000F_FFFF;
    localparam logic [31:0] HEAP_BASE     = 32'h1000_0000;
    localparam logic [31:0] HEAP_LIMIT    = 32'h8FFF_FFFF;
    localparam logic [31:0] STACK_BASE    = 32'hD000_0000;
    localparam logic [31:0] STACK_LIMIT   = 32'hD000_FFFF;
    localparam logic [31:0] LCD_DATA_ADDR = 32'hFFFF_0000;
    localparam logic [31:0] LCD_CTRL_ADDR = 32'hFFFF_0001;
    localparam logic [31:0] PAGE_ADDR     = 32'hFFFF_1000;
    localparam logic [31:0] INT_EN_ADDR   = 32'hFFFF_FFFD;
    localparam logic [31:0] INT_LO_ADDR   = 32'hFFFF_FFFE;
    localparam logic [31:0] INT_HI_ADDR   = 32'hFFFF_FFFF;

    typedef enum logic [3:0] {
        NONE, ROM, HEAP, STACK, LCD_DATA, LCD_CTRL, PAGE, INT_EN, INT_LO, INT_HI
    } region_e;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_e;

    function automatic region_e decodeRegion(input logic [31:0] a);
        region_e r;
        r = NONE;
        // ROM window is power-of-two aligned, so a mask test covers both bounds.
        if ((a & ~ROM_LIMIT) == ROM_BASE)             r = ROM;
        else if (a >= HEAP_BASE && a <= HEAP_LIMIT)   r = HEAP;
        else if (a >= STACK_BASE && a <= STACK_LIMIT) r = STACK;
        else begin
            case (a)
                LCD_DATA_ADDR: r = LCD_DATA;
                LCD_CTRL_ADDR: r = LCD_CTRL;
                PAGE_ADDR:     r = PAGE;
                INT_EN_ADDR:   r = INT_EN;
                INT_LO_ADDR:   r = INT_LO;
                INT_HI_ADDR:   r = INT_HI;
                default:       r = NONE;
            endcase
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_sram.sv
// Single-port synchronous RAM with a LAT-stage registered read pipeline.
// Latency: q reflects mem[addr] LAT cycles after addr is presented.
// Backpressure: none; the controller owns sequencing.
module bus_sram #(
    parameter int AW  = 10,
    parameter int DW  = 16,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem  [0:(1<<AW)-1];
    logic [DW-1:0] pipe [0:LAT-1];

    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
        pipe[0] <= mem[addr];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign q = pipe[LAT-1];

endmodule

// File: rtl/mem_bus_ctrl.sv
// Address decode + req/ack sequencer for ROM, heap/stack RAM and MMIO registers.
// Latency: 1 cycle after acceptance for writes/MMIO/unmapped, 1+MEM_RD_LAT for memory reads.
// Backpressure: req ignored while busy; MEM_BUS_CTRL_MMIO_READBACK_EN enables MMIO register reads.
module mem_bus_ctrl
    import mem_bus_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ROM_AW     = 10,
    parameter int STACK_AW   = 10,
    parameter int HEAP_AW    = 12,
    parameter int MEM_RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ack,
    output logic              err,
    output logic              busy,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    output logic [10:0]       lcd_pins,
    output logic [15:0]       page,
    output logic [31:0]       int_addr,
    output logic              int_en
);

    localparam int CNT_W = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_RD_LAT - 1);
    localparam int XW = (DATA_W > 16) ? DATA_W : 16;

    state_e            state, stateNext;
    region_e           region;
    logic [31:0]       addrReg;
    logic              weReg;
    logic [DATA_W-1:0] wdataReg;
    logic [XW-1:0]     wdataX;
    logic [CNT_W-1:0]  waitCnt;
    logic [7:0]        lcdData;
    logic [2:0]        lcdCtrl;
    logic [15:0]       pageReg, intLo, intHi, mmioVal;
    logic              intEnReg;
    logic              ackNext, errNext, stackWe, heapWe, mmioWr, isMem;
    logic [DATA_W-1:0] rdataNext, stackQ, heapQ, memQ;

    assign region   = decodeRegion(addrReg);
    assign isMem    = (region == ROM) || (region == HEAP) || (region == STACK);
    assign wdataX   = XW'(wdataReg);
    assign rom_addr = addrReg[ROM_AW-1:0];
    assign busy     = (state != IDLE);
    assign lcd_pins = {lcdCtrl, lcdData};
    assign page     = pageReg;
    assign int_addr = {intHi, intLo};
    assign int_en   = intEnReg;

`ifdef MEM_BUS_CTRL_MMIO_READBACK_EN
    always_comb begin
        mmioVal = '0;
        case (region)
            LCD_DATA: mmioVal = {8'h00, lcdData};
            LCD_CTRL: mmioVal = {13'h0000, lcdCtrl};
            PAGE:     mmioVal = pageReg;
            INT_EN:   mmioVal = {15'h0000, intEnReg};
            INT_LO:   mmioVal = intLo;
            INT_HI:   mmioVal = intHi;
            default:  mmioVal = '0;
        endcase
    end
`else
    assign mmioVal = '0;
`endif

    always_comb begin
        case (region)
            STACK:   memQ = stackQ;
            HEAP:    memQ = heapQ;
            default: memQ = rom_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        ackNext   = 1'b0;
        errNext   = 1'b0;
        rdataNext = '0;
        stackWe   = 1'b0;
        heapWe    = 1'b0;
        mmioWr    = 1'b0;
        case (state)
            IDLE: if (req) stateNext = ACCESS;
            ACCESS: begin
                if (!weReg && isMem) begin
                    stateNext = WAIT;
                end else begin
                    stateNext = IDLE;
                    ackNext   = 1'b1;
                    errNext   = (region == NONE);
                    mmioWr    = weReg;
                    // rst gate keeps a write aborted in this cycle out of the RAM.
                    stackWe   = weReg && (region == STACK) && !rst;
                    heapWe    = weReg && (region == HEAP) && !rst;
                    if (!weReg) rdataNext = DATA_W'(mmioVal);
                end
            end
            WAIT: begin
                if (waitCnt == CNT_LAST) begin
                    stateNext = IDLE;
                    ackNext   = 1'b1;
                    rdataNext = memQ;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack      <= 1'b0;
            err      <= 1'b0;
            rdata    <= '0;
            addrReg  <= '0;
            weReg    <= 1'b0;
            wdataReg <= '0;
            waitCnt  <= '0;
            lcdData  <= '0;
            lcdCtrl  <= '0;
            pageReg  <= '0;
            intLo    <= '0;
            intHi    <= '0;
            intEnReg <= 1'b1;
        end else begin
            ack     <= ackNext;
            err     <= errNext;
            rdata   <= rdataNext;
            waitCnt <= (state == WAIT) ? waitCnt + CNT_W'(1) : '0;
            if (state == IDLE && req) begin
                addrReg  <= addr;
                weReg    <= we;
                wdataReg <= wdata;
            end
            if (mmioWr) begin
                case (region)
                    LCD_DATA: lcdData  <= wdataX[7:0];
                    LCD_CTRL: lcdCtrl  <= wdataX[2:0];
                    PAGE:     pageReg  <= wdataX[15:0];
                    INT_EN:   intEnReg <= |wdataReg;
                    INT_LO:   intLo    <= wdataX[15:0];
                    INT_HI:   intHi    <= wdataX[15:0];
                    default: ;
                endcase
            end
        end
    end

    bus_sram #(.AW(STACK_AW), .DW(DATA_W), .LAT(MEM_RD_LAT)) uStack (
        .clk   (clk),
        .we    (stackWe),
        .addr  (addrReg[STACK_AW-1:0]),
        .wdata (wdataReg),
        .q     (stackQ)
    );

    bus_sram #(.AW(HEAP_AW), .DW(DATA_W), .LAT(MEM_RD_LAT)) uHeap (
        .clk   (clk),
        .we    (heapWe),
        .addr  (addrReg[HEAP_AW-1:0]),
        .wdata (wdataReg),
        .q     (heapQ)
    );

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed + randomized bench for mem_bus_ctrl against a region-level reference model.
module tb_mem_bus_ctrl;

    localparam int DATA_W     = 16;
    localparam int ROM_AW     = 10;
    localparam int STACK_AW   = 10;
    localparam int HEAP_AW    = 12;
    localparam int MEM_RD_LAT = 1;

    logic        clk = 1'b0;
    logic        rst, req, we;
    logic [31:0] addr;
    logic [15:0] wdata, rdata, rom_q;
    logic        ack, err, busy;
    logic [9:0]  rom_addr;
    logic [10:0] lcd_pins;
    logic [15:0] page;
    logic [31:0] int_addr;
    logic        int_en;

    int checks = 0;
    int errors = 0;

    mem_bus_ctrl #(
        .DATA_W(DATA_W), .ROM_AW(ROM_AW), .STACK_AW(STACK_AW),
        .HEAP_AW(HEAP_AW), .MEM_RD_LAT(MEM_RD_LAT)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .err(err), .busy(busy), .rom_addr(rom_addr),
        .rom_q(rom_q), .lcd_pins(lcd_pins), .page(page), .int_addr(int_addr),
        .int_en(int_en)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] romVal(input logic [9:0] a);
        return {6'h15, a} ^ 16'h3C3C;
    endfunction

    // External ROM with one cycle of read latency.
    always @(posedge clk) rom_q <= romVal(rom_addr);

    // Reference model state
    logic [15:0] mStack [int];
    logic [15:0] mHeap  [int];
    logic [7:0]  mLcdD;
    logic [2:0]  mLcdC;
    logic [15:0] mPage, mIntLo, mIntHi;
    logic        mIntEn;

    logic [31:0] mmioList [7] = '{32'hFFFF_0000, 32'hFFFF_0001, 32'hFFFF_1000,
                                  32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    logic [31:0] noneList [6] = '{32'h0010_0000, 32'h9000_0000, 32'hD001_0000,
                                  32'hFFFF_0002, 32'hFFFF_FFFC, 32'h0FFF_FFFF};

    task automatic mReset();
        mLcdD = '0; mLcdC = '0; mPage = '0; mIntLo = '0; mIntHi = '0; mIntEn = 1'b1;
    endtask

    // 0 none, 1 rom, 2 heap, 3 stack, 4 lcd data, 5 lcd ctrl, 6 page, 7 int_en, 8 int_lo, 9 int_hi
    function automatic int rgnOf(input logic [31:0] a);
        if (a < 32'h0010_0000) return 1;
        if (a >= 32'h1000_0000 && a < 32'h9000_0000) return 2;
        if (a >= 32'hD000_0000 && a < 32'hD001_0000) return 3;
        if (a == 32'hFFFF_0000) return 4;
        if (a == 32'hFFFF_0001) return 5;
        if (a == 32'hFFFF_1000) return 6;
        if (a == 32'hFFFF_FFFD) return 7;
        if (a == 32'hFFFF_FFFE) return 8;
        if (a == 32'hFFFF_FFFF) return 9;
        return 0;
    endfunction

    function automatic logic [15:0] mmioModel(input int r);
        case (r)
            4: return {8'h00, mLcdD};
            5: return {13'h0000, mLcdC};
            6: return mPage;
            7: return {15'h0000, mIntEn};
            8: return mIntLo;
            9: return mIntHi;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic mWrite(input logic [31:0] a, input logic [15:0] d);
        case (rgnOf(a))
            2: mHeap[int'(a[11:0])] = d;
            3: mStack[int'(a[9:0])] = d;
            4: mLcdD = d[7:0];
            5: mLcdC = d[2:0];
            6: mPage = d;
            7: mIntEn = |d;
            8: mIntLo = d;
            9: mIntHi = d;
            default: ;
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkOuts(input string tag);
        chk({tag, "_lcd"}, {21'h0, lcd_pins}, {21'h0, mLcdC, mLcdD});
        chk({tag, "_page"}, {16'h0, page}, {16'h0, mPage});
        chk({tag, "_intaddr"}, int_addr, {mIntHi, mIntLo});
        chk({tag, "_inten"}, {31'h0, int_en}, {31'h0, mIntEn});
    endtask

    task automatic doTxn(input bit w, input logic [31:0] a, input logic [15:0] d, input string tag);
        int r, lat, expLat;
        logic [15:0] expRd;
        r      = rgnOf(a);
        expRd  = 16'h0000;
        expLat = (!w && r >= 1 && r <= 3) ? 1 + MEM_RD_LAT : 1;
        if (!w) begin
            case (r)
                1: expRd = romVal(a[9:0]);
                2: expRd = mHeap[int'(a[11:0])];
                3: expRd = mStack[int'(a[9:0])];
                default: begin
`ifdef MEM_BUS_CTRL_MMIO_READBACK_EN
                    expRd = mmioModel(r);
`endif
                end
            endcase
        end
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0;
        chk({tag, "_busy_rise"}, {31'h0, busy}, 32'd1);
        lat = 0;
        while (lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (ack) break;
        end
        chk({tag, "_lat"}, lat, expLat);
        chk({tag, "_err"}, {31'h0, err}, {31'h0, (r == 0)});
        chk({tag, "_rdata"}, {16'h0, rdata}, {16'h0, expRd});
        chk({tag, "_busy_ack"}, {31'h0, busy}, 32'd0);
        if (w) mWrite(a, d);
        @(posedge clk); #1;
        chk({tag, "_ack_pulse"}, {31'h0, ack}, 32'd0);
        chk({tag, "_rdata_clr"}, {16'h0, rdata}, 32'd0);
        chk({tag, "_err_clr"}, {31'h0, err}, 32'd0);
        chkOuts(tag);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int          acks, accepts, k;
    bit          w;
    bit          ackSeen;
    logic [31:0] a;
    logic [15:0] d;

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
        mReset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_ack", {31'h0, ack}, 32'd0);
        chk("rst_err", {31'h0, err}, 32'd0);
        chk("rst_busy", {31'h0, busy}, 32'd0);
        chk("rst_rdata", {16'h0, rdata}, 32'd0);
        chkOuts("rst");

        // Stack write then readback
        doTxn(1'b1, 32'hD000_0005, 16'h1234, "stk_wr");
        doTxn(1'b0, 32'hD000_0005, 16'h0000, "stk_rd");
        // Heap aliasing across HEAP_AW
        doTxn(1'b1, 32'h1000_0003, 16'hBEEF, "heap_wr");
        doTxn(1'b0, 32'h1000_1003, 16'h0000, "heap_alias");
        // Interrupt vector and LCD
        doTxn(1'b1, 32'hFFFF_FFFE, 16'h5678, "int_lo");
        doTxn(1'b1, 32'hFFFF_FFFF, 16'h0001, "int_hi");
        doTxn(1'b1, 32'hFFFF_FFFD, 16'h0000, "int_en");
        chk("int_vec", int_addr, 32'h0001_5678);
        chk("int_en_low", {31'h0, int_en}, 32'd0);
        doTxn(1'b1, 32'hFFFF_0001, 16'h0007, "lcd_ctrl");
        chk("lcd_ctrl_bits", {29'h0, lcd_pins[10:8]}, 32'd7);
        // Unmapped and MMIO reads
        doTxn(1'b0, 32'h9000_0000, 16'h0000, "none_rd");
        doTxn(1'b0, 32'hFFFF_FFFE, 16'h0000, "int_lo_rd");
        doTxn(1'b1, 32'h0000_0040, 16'hFFFF, "rom_wr");
        doTxn(1'b0, 32'h0000_0040, 16'h0000, "rom_rd");

        // req held for 10 cycles with alternating write targets
        acks = 0; accepts = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (ack) acks++;
            req   = 1'b1;
            we    = 1'b1;
            addr  = ((i % 4) < 2) ? 32'hD000_0020 : 32'hFFFF_1000;
            wdata = 16'h0100 + 16'(i);
            if (!busy) begin
                accepts++;
                mWrite(addr, wdata);
            end
        end
        @(negedge clk);
        if (ack) acks++;
        req = 1'b0; we = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ack) acks++;
        end
        chk("burst_acks", acks, 32'd5);
        chk("burst_accepts", accepts, 32'd5);
        chkOuts("burst");
        doTxn(1'b0, 32'hD000_0020, 16'h0000, "burst_rd");

        // Reset during the ACCESS cycle of a stack write
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'hD000_0005; wdata = 16'hAAAA;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
        chk("abort_busy", {31'h0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_ack", {31'h0, ack}, 32'd0);
        rst = 1'b0;
        mReset();
        chk("abort_busy_clr", {31'h0, busy}, 32'd0);
        chk("abort_err", {31'h0, err}, 32'd0);
        chk("abort_rdata", {16'h0, rdata}, 32'd0);
        chkOuts("abort");
        ackSeen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            ackSeen |= ack;
        end
        chk("abort_no_ack", {31'h0, ackSeen}, 32'd0);
        doTxn(1'b0, 32'hD000_0005, 16'h0000, "abort_old");

        // Randomized traffic across all regions
        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 4);
            w = 1'($urandom_range(0, 1));
            d = 16'($urandom);
            case (k)
                0: begin
                    a = 32'hD000_0000 | 32'($urandom_range(0, 32'hFFFF));
                    if (!w && !mStack.exists(int'(a[9:0]))) w = 1'b1;
                end
                1: begin
                    a = 32'h1000_0000 + ($urandom % 32'h8000_0000);
                    if (!w && !mHeap.exists(int'(a[11:0]))) w = 1'b1;
                end
                2: a = 32'($urandom_range(0, 32'h000F_FFFF));
                3: a = mmioList[$urandom_range(0, 6)];
                default: a = noneList[$urandom_range(0, 5)];
            endcase
            doTxn(w, a, d, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
